// File: rtl/capture_pkg.sv
// Shared types and defaults for the data-memory store capture block.
package capture_pkg;
  localparam int          CAP_DEPTH     = 8;
  localparam logic [31:0] CAP_DONE_ADDR = 32'd84;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] data;
  } cap_entry_t;
endpackage

// File: rtl/sync_fifo.sv
// First-word-fall-through synchronous FIFO; occupancy counter drives full/empty.
module sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 8,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [DEPTH-1:0][WIDTH-1:0] mem_q;
  logic [AW-1:0]               wr_ptr_q, rd_ptr_q;
  logic [AW:0]                 count_q, count_d;
  logic                        push_ok, pop_ok;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_CNT);
  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign pop_ok  = pop && !empty;
  assign push_ok = push && (!full || pop_ok);
  assign dout    = mem_q[rd_ptr_q];
  assign count   = count_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) begin
        mem_q[wr_ptr_q] <= din;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop_ok) rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end
endmodule

// File: rtl/store_capture.sv
// Passive bus observer: queues aligned in-window stores, latches the first DONE store.
module store_capture
  import capture_pkg::*;
#(
  parameter int          DEPTH     = CAP_DEPTH,
  parameter logic [31:0] WIN_LO    = 32'h0000_0000,
  parameter logic [31:0] WIN_HI    = 32'h0000_00FF,
  parameter logic [31:0] DONE_ADDR = CAP_DONE_ADDR
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     memwrite,
  input  logic [31:0]              dataadr,
  input  logic [31:0]              writedata,
  input  logic                     rd_ready,
  output logic                     rd_valid,
  output logic [31:0]              rd_addr,
  output logic [31:0]              rd_data,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow,
  output logic                     misaligned,
  output logic                     done,
  output logic [31:0]              done_data
);
  cap_entry_t push_ent, head_ent;
  logic       aligned, in_win, push, pop, full, empty;
  logic       overflow_q, overflow_d, misaligned_q, misaligned_d;
  logic       done_q, done_d;
  logic [31:0] done_data_q, done_data_d;

  assign aligned = (dataadr[1:0] == 2'b00);
  // 33-bit signed compare keeps a zero lower bound from being a constant-true test.
  assign in_win  = ($signed({1'b0, dataadr}) >= $signed({1'b0, WIN_LO})) &&
                   ($signed({1'b0, dataadr}) <= $signed({1'b0, WIN_HI}));
  assign push    = memwrite && aligned && in_win;
  assign pop     = rd_ready && rd_valid;
  assign push_ent = '{addr: dataadr, data: writedata};

  sync_fifo #(.WIDTH($bits(cap_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (push),
    .pop   (pop),
    .din   (push_ent),
    .dout  (head_ent),
    .full  (full),
    .empty (empty),
    .count (count)
  );

  always_comb begin
    overflow_d   = overflow_q;
    misaligned_d = misaligned_q;
    done_d       = done_q;
    done_data_d  = done_data_q;
    if (push && full && !pop)             overflow_d   = 1'b1;
    if (memwrite && !aligned)             misaligned_d = 1'b1;
    if (memwrite && aligned && (dataadr == DONE_ADDR) && !done_q) begin
      done_d      = 1'b1;
      done_data_d = writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      overflow_q   <= 1'b0;
      misaligned_q <= 1'b0;
      done_q       <= 1'b0;
      done_data_q  <= '0;
    end else begin
      overflow_q   <= overflow_d;
      misaligned_q <= misaligned_d;
      done_q       <= done_d;
      done_data_q  <= done_data_d;
    end
  end

  assign rd_valid   = !empty;
  assign rd_addr    = head_ent.addr;
  assign rd_data    = head_ent.data;
  assign overflow   = overflow_q;
  assign misaligned = misaligned_q;
  assign done       = done_q;
  assign done_data  = done_data_q;
endmodule

// File: tb/tb_store_capture.sv
// Directed bench for store_capture with hand-computed expectations.
module tb_store_capture;
  logic        clk = 1'b0, reset = 1'b1;
  logic        memwrite = 1'b0, rd_ready = 1'b0;
  logic [31:0] dataadr = '0, writedata = '0;
  logic        rd_valid, overflow, misaligned, done;
  logic [31:0] rd_addr, rd_data, done_data;
  logic [3:0]  count;
  int          n_cmp = 0, n_bad = 0;

  store_capture dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .dataadr(dataadr),
    .writedata(writedata), .rd_ready(rd_ready), .rd_valid(rd_valid),
    .rd_addr(rd_addr), .rd_data(rd_data), .count(count), .overflow(overflow),
    .misaligned(misaligned), .done(done), .done_data(done_data)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle of bus/host activity; inputs return to idle 1 time unit after the edge.
  task automatic step(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rdy);
    memwrite = we; dataadr = a; writedata = d; rd_ready = rdy;
    @(posedge clk); #1;
    memwrite = 1'b0; rd_ready = 1'b0;
  endtask

  task automatic head(input string tag, input logic [31:0] a, input logic [31:0] d);
    chk({tag, "_valid"}, rd_valid, 1'b1);
    chk({tag, "_addr"}, rd_addr, a);
    chk({tag, "_data"}, rd_data, d);
  endtask

  task automatic do_reset();
    @(negedge clk); reset = 1'b1;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
  endtask

  initial begin
    #2;
    chk("rst0_valid", rd_valid, 1'b0);
    chk("rst0_count", count, 4'd0);
    chk("rst0_addr", rd_addr, 32'd0);
    chk("rst0_data", rd_data, 32'd0);
    chk("rst0_flags", {overflow, misaligned, done}, 3'b000);
    chk("rst0_done_data", done_data, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;

    // reset mid-cycle with 3 entries queued
    step(1, 32'd4, 32'd1, 0);
    step(1, 32'd8, 32'd2, 0);
    step(1, 32'd84, 32'd99, 0);
    step(1, 32'd6, 32'd0, 0);
    chk("pre_rst_count", count, 4'd3);
    chk("pre_rst_flags", {misaligned, done}, 2'b11);
    #3 reset = 1'b1;
    #1;
    chk("mid_rst_valid", rd_valid, 1'b0);
    chk("mid_rst_count", count, 4'd0);
    chk("mid_rst_addr", rd_addr, 32'd0);
    chk("mid_rst_data", rd_data, 32'd0);
    chk("mid_rst_flags", {overflow, misaligned, done}, 3'b000);
    chk("mid_rst_done_data", done_data, 32'd0);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_valid", rd_valid, 1'b0);
    chk("post_rst_count", count, 4'd0);

    // capture and drain
    step(1, 32'd80, 32'd5, 0);
    head("push_lat", 32'd80, 32'd5);
    step(1, 32'd84, 32'd7, 0);
    chk("cap_count", count, 4'd2);
    head("cap_head", 32'd80, 32'd5);
    chk("cap_done", done, 1'b1);
    chk("cap_done_data", done_data, 32'd7);
    step(0, 32'd0, 32'd0, 1);
    head("drain1", 32'd84, 32'd7);
    step(0, 32'd0, 32'd0, 1);
    chk("drain_empty", rd_valid, 1'b0);
    chk("drain_count", count, 4'd0);

    // window and alignment
    step(1, 32'd256, 32'd11, 0);
    chk("win_hi_count", count, 4'd0);
    chk("win_hi_mis", misaligned, 1'b0);
    step(1, 32'h3FC, 32'd12, 0);
    chk("win_3fc_count", count, 4'd0);
    chk("win_3fc_mis", misaligned, 1'b0);
    step(1, 32'd82, 32'd13, 0);
    chk("mis_count", count, 4'd0);
    chk("mis_flag", misaligned, 1'b1);
    // rd_ready ignored while empty
    step(0, 32'd0, 32'd0, 1);
    chk("rdy_empty_count", count, 4'd0);

    // overflow: 9 stores into 8 slots
    for (int i = 0; i < 9; i++) step(1, 32'(4 * i), 32'(100 + i), 0);
    chk("ovf_count", count, 4'd8);
    chk("ovf_flag", overflow, 1'b1);
    for (int i = 0; i < 8; i++) begin
      head($sformatf("ovf_order%0d", i), 32'(4 * i), 32'(100 + i));
      step(0, 32'd0, 32'd0, 1);
    end
    chk("ovf_drained", rd_valid, 1'b0);

    // full with simultaneous push and pop
    do_reset();
    for (int i = 0; i < 8; i++) step(1, 32'(4 * i), 32'(200 + i), 0);
    chk("full_count", count, 4'd8);
    chk("full_no_ovf", overflow, 1'b0);
    step(1, 32'd40, 32'd9, 1);
    chk("fpp_count", count, 4'd8);
    chk("fpp_ovf", overflow, 1'b0);
    for (int i = 1; i < 8; i++) begin
      head($sformatf("fpp_order%0d", i), 32'(4 * i), 32'(200 + i));
      step(0, 32'd0, 32'd0, 1);
    end
    head("fpp_tail", 32'd40, 32'd9);
    step(0, 32'd0, 32'd0, 1);
    chk("fpp_empty", rd_valid, 1'b0);

    // pointer wrap with streaming pops, then DONE behaviour
    step(1, 32'd84, 32'd7, 0);
    chk("wrap_done_data", done_data, 32'd7);
    step(0, 32'd0, 32'd0, 1);
    for (int i = 0; i < 20; i++) begin
      step(1, 32'(128 + 4 * (i % 16)), 32'(300 + i), 1);
      head($sformatf("wrap%0d", i), 32'(128 + 4 * (i % 16)), 32'(300 + i));
      chk($sformatf("wrap%0d_count", i), count, 4'd1);
    end
    step(0, 32'd0, 32'd0, 1);
    chk("wrap_empty", rd_valid, 1'b0);
    step(1, 32'd84, 32'd3, 0);
    chk("done2_data", done_data, 32'd7);
    chk("done2_flag", done, 1'b1);
    head("done2_pushed", 32'd84, 32'd3);
    chk("done2_count", count, 4'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1);
  end
endmodule
